// File: rtl/sprite_shifter.sv
// sprite_shifter: per-sprite pixel serializer for all sprites.
//   Holds each sprite's 24-bit line pattern and starts shifting it out when
//   the raster x position matches the sprite x coordinate. It applies
//   x-expansion and multicolor pairing, and presents one registered 2-bit
//   pixel code per sprite per dot.
// Ports:
//   clk_dot4x        4x dot clock
//   rst              synchronous active-high reset
//   dot_rising_0     dot tick qualifier; all shift state advances only on ticks
//   xpos             current raster x position
//   sprite_x         9-bit x coordinate per sprite, sprite n at [9n +: 9]
//   sprite_disp      per-sprite display enable for the current line
//   sprite_xe        x-expand enables (sampled at load)
//   sprite_mmc       multicolor enables (sampled at load)
//   pat_we           pattern byte write strobe (any cycle)
//   pat_sprite       sprite index for the write
//   pat_byte         0 -> [23:16], 1 -> [15:8], 2 -> [7:0], 3 ignored
//   pat_data         pattern byte
//   sprite_cur_pixel 2-bit pixel code per sprite, sprite n at [2n +: 2]

`ifndef NUM_SPRITES
`define NUM_SPRITES 8
`endif

module sprite_shifter (
    input  logic                          clk_dot4x,
    input  logic                          rst,
    input  logic                          dot_rising_0,
    input  logic [9:0]                    xpos,
    input  logic [9*`NUM_SPRITES-1:0]     sprite_x,
    input  logic [`NUM_SPRITES-1:0]       sprite_disp,
    input  logic [`NUM_SPRITES-1:0]       sprite_xe,
    input  logic [`NUM_SPRITES-1:0]       sprite_mmc,
    input  logic                          pat_we,
    input  logic [2:0]                    pat_sprite,
    input  logic [1:0]                    pat_byte,
    input  logic [7:0]                    pat_data,
    output logic [2*`NUM_SPRITES-1:0]     sprite_cur_pixel
);

    localparam int unsigned NUM_SPR = `NUM_SPRITES;
    localparam int unsigned PAT_W   = 24;
    localparam int unsigned BL_W    = 5;
    localparam int unsigned X_W     = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    for (genvar n = 0; n < NUM_SPR; n++) begin : g_spr
        state_t             state_q, state_d;
        logic [PAT_W-1:0]   pat_buf_q;
        logic [PAT_W-1:0]   sr_q, sr_d;
        logic [BL_W-1:0]    bits_left_q, bits_left_d;
        logic               xe_q, xe_d;
        logic               mc_q, mc_d;
        logic [1:0]         ph_q, ph_d;
        logic [1:0]         pix_q, pix_d;
        logic [BL_W-1:0]    step;
        logic [1:0]         ph_last;
        logic               x_match;

        // Pattern staging buffer; writes land regardless of the dot tick.
        always_ff @(posedge clk_dot4x) begin
            if (rst) begin
                pat_buf_q <= '0;
            end else if (pat_we && (pat_sprite == 3'(n))) begin
                case (pat_byte)
                    2'd0:    pat_buf_q[23:16] <= pat_data;
                    2'd1:    pat_buf_q[15:8]  <= pat_data;
                    2'd2:    pat_buf_q[7:0]   <= pat_data;
                    default: pat_buf_q        <= pat_buf_q;
                endcase
            end
        end

        // Shifter state register.
        always_ff @(posedge clk_dot4x) begin
            if (rst) begin
                state_q     <= IDLE;
                sr_q        <= '0;
                bits_left_q <= '0;
                xe_q        <= 1'b0;
                mc_q        <= 1'b0;
                ph_q        <= '0;
                pix_q       <= '0;
            end else begin
                state_q     <= state_d;
                sr_q        <= sr_d;
                bits_left_q <= bits_left_d;
                xe_q        <= xe_d;
                mc_q        <= mc_d;
                ph_q        <= ph_d;
                pix_q       <= pix_d;
            end
        end

        // Last phase of a step: D-1 where D = (mc ? 2 : 1) * (xe ? 2 : 1).
        assign ph_last = {mc_q & xe_q, mc_q | xe_q};
        assign step    = mc_q ? BL_W'(2) : BL_W'(1);
        assign x_match = ({1'b0, sprite_x[n*X_W +: X_W]} == xpos);

        // Next state; pixel code is derived from the next state so a load
        // is visible right after its tick edge.
        always_comb begin
            state_d     = state_q;
            sr_d        = sr_q;
            bits_left_d = bits_left_q;
            xe_d        = xe_q;
            mc_d        = mc_q;
            ph_d        = ph_q;

            if (dot_rising_0) begin
                case (state_q)
                    IDLE: begin
                        if (x_match && sprite_disp[n]) begin
                            state_d     = SHIFT;
                            sr_d        = pat_buf_q;
                            bits_left_d = BL_W'(PAT_W);
                            xe_d        = sprite_xe[n];
                            mc_d        = sprite_mmc[n];
                            ph_d        = '0;
                        end
                    end
                    SHIFT: begin
                        if (ph_q == ph_last) begin
                            ph_d        = '0;
                            sr_d        = mc_q ? {sr_q[PAT_W-3:0], 2'b00}
                                               : {sr_q[PAT_W-2:0], 1'b0};
                            bits_left_d = bits_left_q - step;
                            if (bits_left_q <= step) begin
                                state_d = IDLE;
                            end
                        end else begin
                            ph_d = ph_q + 2'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            pix_d = 2'b00;
            if (state_d == SHIFT) begin
                pix_d = mc_d ? sr_d[PAT_W-1:PAT_W-2] : {sr_d[PAT_W-1], 1'b0};
            end
        end

        assign sprite_cur_pixel[n*2 +: 2] = pix_q;
    end

endmodule

// File: doc/sprite_shifter.md
# sprite_shifter

Per-sprite pixel serializer for all `NUM_SPRITES` (8) sprites. It holds each sprite's 24-bit line pattern, starts shifting when the raster x position matches the sprite's x coordinate, and applies x-expansion and multicolor pairing. Once per dot it presents a 2-bit pixel code per sprite on `sprite_cur_pixel`. It sits directly upstream of the pixel sequencer, which delays, prioritizes and colors these codes.

## Interface
Parameters
- none; sprite count is the `NUM_SPRITES` macro (8) from common.vh.

Ports
- clk_dot4x  in  1  4x dot clock, sole clock.
- rst  in  1  reset, synchronous, active-high.
- dot_rising_0  in  1  one-cycle dot tick qualifier; all state advances only on ticks.
- xpos  in  10  current raster x position.
- sprite_x  in  9 x NUM_SPRITES  sprite x coordinates.
- sprite_disp  in  8  per-sprite display enable for the current raster line.
- sprite_xe  in  8  x-expand enables.
- sprite_mmc  in  8  multicolor enables.
- pat_we  in  1  pattern byte write strobe; any clk_dot4x cycle, tick not required.
- pat_sprite  in  3  sprite index for the write.
- pat_byte  in  2  byte index: 0 writes [23:16], 1 writes [15:8], 2 writes [7:0], 3 is ignored.
- pat_data  in  8  pattern byte.
- sprite_cur_pixel  out  2 x NUM_SPRITES  pixel code per sprite, registered.

## Operation
Per-sprite state
- pat_buf[23:0]: the staging pattern.
- sr[23:0]: the shift register.
- active: the state flag, IDLE = 0, SHIFT = 1.
- bits_left[4:0]: bits not yet consumed.
- xe_l, mc_l: latched mode bits.
- ph[1:0]: the dot phase counter.

IDLE -> SHIFT transition
- Taken on a tick when `{1'b0, sprite_x[n]} == xpos`, `sprite_disp[n] == 1` and `active == 0`.
- Loads `sr <= pat_buf` and `bits_left <= 24`.
- Latches `xe_l <= sprite_xe[n]` and `mc_l <= sprite_mmc[n]`.
- Sets `ph <= 0`.

SHIFT behaviour, on each tick
- Dots per step: D = (mc_l ? 2 : 1) * (xe_l ? 2 : 1).
- `ph` increments modulo D. When `ph == D-1`, sr shifts left by (mc_l ? 2 : 1), zero-filled, and bits_left decreases by the same amount.
- When bits_left would reach 0, the register goes to IDLE on that tick.

Output encoding
- In SHIFT: `mc_l ? sr[23:22] : {sr[23], 1'b0}`.
- In IDLE: 2'b00.

Boundary rules
- An x match while in SHIFT is ignored; there is no retrigger or restart.
- Clearing sprite_disp, sprite_xe or sprite_mmc mid-line does not affect a sprite already in SHIFT. The mode bits are sampled only at load.
- pat_we in the same cycle as a load: sr takes the pre-write pat_buf. The write still lands in pat_buf.
- pat_byte == 3: no state change.
- xpos values above 511 never match.
- The 8 sprites are fully independent; several may load on the same tick.

Reset
- All outputs 2'b00.
- active = 0, sr = 0, pat_buf = 0, bits_left = 0, ph = 0.
- A reset mid-shift aborts immediately, and the output reads 00 from the next clk_dot4x edge.

## Timing
- Load latency: when the match tick is at clk_dot4x edge k, the first pixel code is visible after edge k. It holds until the next tick edge.
- Dots the output stays non-zero-capable (in SHIFT):
  - mono, no expand: 24.
  - mono, expanded: 48.
  - multicolor: 24, as 12 pairs of 2 dots each.
  - multicolor, expanded: 48, as 12 pairs of 4 dots each.
- Return to IDLE on the tick that consumes the last bit. The output is 00 from that tick onward.
- No output change occurs on non-tick clk_dot4x cycles.
- The pattern write latency to pat_buf is one clk_dot4x cycle.

## Test plan
- **Reset:** assert rst for 3 cycles mid-shift -> all sprite_cur_pixel = 00; active clear; no output until the next match.
- **Mono, no expand:** pattern 0xA00001 into sprite 0, sprite_x = 24, disp = 1; ticks at xpos 24.. -> output [1] follows 1,0,1,0,...,0,1 over 24 dots, then 00 from dot 48.
- **Expanded multicolor:** sprite 3 with xe = 1, mmc = 1, pattern 0x1B0000 -> pairs 00,01,10,11 each held 4 dots (16 dots), then 00 pairs; 48 dots total, IDLE at tick 48.
- **Retrigger and mid-line mode change:** on sprite 5, xpos wraps to re-match at offset 10 and sprite_xe toggles mid-line -> shift is unaffected; 24 dots total.
- **Simultaneous write and load:** pat_we on the load cycle with 0xFF to byte 0, old buffer 0x000000 -> sprite outputs all 00; the next line shows 0xFF0000.
- **All 8 sprites:** same sprite_x, distinct patterns, disp = 0x5A -> only sprites 1, 3, 4 and 6 shift; the others stay 00.
